// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Used by multiplicador and multiplicador_dp.
package multiplicador_pkg;

    localparam int unsigned MultWidthDef = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multiplicador_dp.sv
// Shift-and-add datapath: multiplicand, multiplier, accumulator and iteration counter.
// Build option MULT_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module multiplicador_dp
    import multiplicador_pkg::*;
#(
    parameter int unsigned N = MultWidthDef
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_acc_next,
    output logic           o_last
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;

    logic [2*N-1:0] w_acc_next;

    // Accumulator value after the current iteration; becomes the product on the last one.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_acc_next = w_acc_next;

`ifdef MULT_EARLY_EXIT_EN
    assign o_last = (r_cnt == LastCnt) || ((r_mplier >> 1) == '0);
`else
    assign o_last = (r_cnt == LastCnt);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multiplicador.sv
// Sequential unsigned multiplier with valid/done/ack handshake (FSM + result registers).
// Build option MULT_EARLY_EXIT_EN enables data-dependent latency in multiplicador_dp.
module multiplicador
    import multiplicador_pkg::*;
#(
    parameter int unsigned N = MultWidthDef
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           valid_data,
    input  logic           ack,
    output logic [2*N-1:0] producto,
    output logic           Done_Flag,
    output logic           ret_ack
);

    state_e         r_state;
    state_e         w_state_next;
    logic [2*N-1:0] r_producto;
    logic           r_done;
    logic           r_ret_ack;

    logic           w_load;
    logic           w_step;
    logic           w_last;
    logic [2*N-1:0] w_acc_next;

    multiplicador_dp #(
        .N (N)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (a),
        .i_b        (b),
        .o_acc_next (w_acc_next),
        .o_last     (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            StIdle: begin
                if (valid_data) begin
                    w_load       = 1'b1;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (ack) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_producto <= '0;
            r_done     <= 1'b0;
            r_ret_ack  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ret_ack <= (r_state == StDone) && ack;
            if ((r_state == StBusy) && w_last) begin
                r_producto <= w_acc_next;
                r_done     <= 1'b1;
            end else if ((r_state == StDone) && ack) begin
                r_done <= 1'b0;
            end
        end
    end

    assign producto  = r_producto;
    assign Done_Flag = r_done;
    assign ret_ack   = r_ret_ack;

endmodule

// File: tb/tb_multiplicador.sv
// Randomized self-checking bench for multiplicador against a plain-arithmetic model.
// Honours MULT_EARLY_EXIT_EN when computing expected latency.
module tb_multiplicador;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_data;
    logic        ack;
    logic [63:0] producto;
    logic        Done_Flag;
    logic        ret_ack;

    int n_checks = 0;
    int n_errors = 0;

    multiplicador dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .valid_data (valid_data),
        .ack        (ack),
        .producto   (producto),
        .Done_Flag  (Done_Flag),
        .ret_ack    (ret_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    function automatic int model_latency(input logic [31:0] y);
`ifdef MULT_EARLY_EXIT_EN
        int nbits;
        nbits = 0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) nbits = i + 1;
        end
        return (nbits == 0) ? 1 : nbits;
`else
        return 32;
`endif
    endfunction

    // Leaves the bench 1 time unit after the capture edge.
    task automatic start_op(input logic [31:0] ia, input logic [31:0] ib, input bit keep);
        @(negedge clk);
        a          = ia;
        b          = ib;
        valid_data = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) valid_data = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Called 1 time unit after a capture edge; measures, holds, acknowledges.
    task automatic finish_op(input logic [31:0] ia, input logic [31:0] ib, input int hold,
                             input bit chain, input logic [31:0] na, input logic [31:0] nb);
        logic [63:0] exp;
        logic [63:0] prev;
        int          lat;
        bit          stable;
        exp    = model_product(ia, ib);
        prev   = producto;
        stable = 1'b1;
        lat    = 0;
        while (!Done_Flag && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!Done_Flag && producto !== prev) stable = 1'b0;
        end
        check("latency", 64'(lat), 64'(model_latency(ib)));
        check("product", producto, exp);
        check("busy_stable", 64'(stable), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (Done_Flag !== 1'b1 || producto !== exp || ret_ack !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        @(negedge clk);
        ack = 1'b1;
        if (chain) begin
            a          = na;
            b          = nb;
            valid_data = 1'b1;
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ret_ack_pulse", 64'(ret_ack), 64'd1);
        check("done_after_ack", 64'(Done_Flag), 64'd0);
        @(posedge clk);
        #1;
        if (chain) valid_data = 1'b0;
        check("ret_ack_end", 64'(ret_ack), 64'd0);
        check("product_kept", producto, exp);
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input int hold);
        start_op(ia, ib, 1'b0);
        finish_op(ia, ib, hold, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          quiet;
        reset      = 1'b0;
        valid_data = 1'b0;
        ack        = 1'b0;
        a          = '0;
        b          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_producto", producto, 64'd0);
        check("reset_done", 64'(Done_Flag), 64'd0);
        check("reset_ret_ack", 64'(ret_ack), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(32'd10, 32'd10, 1);
        run_op(32'd19347, 32'd0, 2);
        run_op(32'd0, 32'd0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 50);
        check("max_value", producto, 64'hFFFF_FFFE_0000_0001);

        // valid_data held high across ack starts the next operation straight away
        start_op(32'd5, 32'd9, 1'b1);
        finish_op(32'd5, 32'd9, 2, 1'b1, 32'd123, 32'd456);
        finish_op(32'd123, 32'd456, 0, 1'b0, 32'd0, 32'd0);

        // reset during the 10th iteration discards the operation
        start_op(32'hDEAD_BEEF, 32'hFFFF_0001, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midreset_producto", producto, 64'd0);
        check("midreset_done", 64'(Done_Flag), 64'd0);
        check("midreset_ret_ack", 64'(ret_ack), 64'd0);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done_Flag !== 1'b0 || producto !== 64'd0) quiet = 1'b0;
        end
        check("midreset_discard", 64'(quiet), 64'd1);
        run_op(32'd7, 32'd6, 0);
        check("after_reset_42", producto, 64'd42);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 3 == 1) rb = rb >> $urandom_range(31, 0);
            run_op(ra, rb, $urandom_range(3, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
